// File: rtl/char_glyph_renderer.sv
// Text-mode pixel renderer: maps timing coordinates to character buffer and font ROM reads,
// serializes glyph rows to RGB, overlays a blinking underline cursor, and delays syncs to match.
module char_glyph_renderer #(
   parameter int unsigned COLS         = 80,
   parameter int unsigned ROWS         = 30,
   parameter int unsigned ADDR_W       = 12,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [9:0]        h_pos,
   input  logic [9:0]        v_pos,
   input  logic              de_in,
   input  logic              hsync_in,
   input  logic              vsync_in,
   output logic [ADDR_W-1:0] char_addr,
   input  logic [7:0]        char_data,
   output logic [7:0]        font_char,
   output logic [3:0]        font_scanline,
   input  logic [7:0]        font_row,
   input  logic [23:0]       fg_color,
   input  logic [23:0]       bg_color,
   input  logic              cursor_en,
   input  logic [6:0]        cursor_col,
   input  logic [4:0]        cursor_row,
   output logic [23:0]       rgb_out,
   output logic              de_out,
   output logic              hsync_out,
   output logic              vsync_out
);

   localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_FRAMES - 1);

   typedef struct packed {
      logic [2:0] px;
      logic [3:0] scanline;
      logic       de;
      logic       hsync;
      logic       vsync;
      logic       in_range;
      logic       cursor_hit;
   } stage_t;

   logic [6:0]        col;
   logic [5:0]        row;
   logic [3:0]        scan;
   logic              in_range;
   logic              cursor_hit;
   logic [ADDR_W-1:0] addr_calc;
   logic [ADDR_W-1:0] char_addr_q, char_addr_d;
   stage_t            s1_q, s1_d, s2_q, s3_q;
   logic [23:0]       rgb_q, rgb_d;
   logic              de_q, hsync_q, vsync_q;
   logic              pix_bit;
   logic              vsync_prev_q, vsync_rise;
   logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
   logic              blink_phase_q, blink_phase_d;

   assign col  = h_pos[9:3];
   assign row  = v_pos[9:4];
   assign scan = v_pos[3:0];

   always_comb begin
      in_range   = (32'(col) < COLS) && (32'(row) < ROWS);
      // Gating on in_range keeps out-of-grid cursor coordinates inert.
      cursor_hit = cursor_en && blink_phase_q && in_range && (col == cursor_col) &&
                   (row == {1'b0, cursor_row}) && (scan >= 4'd14);
      addr_calc  = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
      char_addr_d = (de_in && in_range) ? addr_calc : char_addr_q;
      s1_d = '{px: h_pos[2:0], scanline: scan, de: de_in, hsync: hsync_in, vsync: vsync_in,
               in_range: in_range, cursor_hit: cursor_hit};
   end

   always_comb begin
      vsync_rise    = vsync_in && !vsync_prev_q;
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (vsync_rise) begin
         if (blink_cnt_q == BlinkLast) begin
            blink_cnt_d   = '0;
            blink_phase_d = !blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   // font_row lines up with stage 3; MSB is the leftmost pixel.
   assign pix_bit = font_row[3'd7 - s3_q.px] ^ s3_q.cursor_hit;

   always_comb begin
      rgb_d = '0;
      if (s3_q.de) begin
         rgb_d = (s3_q.in_range && pix_bit) ? fg_color : bg_color;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         char_addr_q   <= '0;
         s1_q          <= '0;
         s2_q          <= '0;
         s3_q          <= '0;
         rgb_q         <= '0;
         de_q          <= 1'b0;
         hsync_q       <= 1'b0;
         vsync_q       <= 1'b0;
         vsync_prev_q  <= 1'b0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
      end else begin
         char_addr_q   <= char_addr_d;
         s1_q          <= s1_d;
         s2_q          <= s1_q;
         s3_q          <= s2_q;
         rgb_q         <= rgb_d;
         de_q          <= s3_q.de;
         hsync_q       <= s3_q.hsync;
         vsync_q       <= s3_q.vsync;
         vsync_prev_q  <= vsync_in;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
      end
   end

   assign char_addr     = char_addr_q;
   assign font_char     = char_data;
   assign font_scanline = s2_q.scanline;
   assign rgb_out       = rgb_q;
   assign de_out        = de_q;
   assign hsync_out     = hsync_q;
   assign vsync_out     = vsync_q;

endmodule

// File: tb/tb_char_glyph_renderer.sv
// Directed bench for char_glyph_renderer with registered buffer-RAM and font-ROM models.
module tb_char_glyph_renderer;

   localparam int unsigned COLS         = 80;
   localparam int unsigned ROWS         = 30;
   localparam int unsigned ADDR_W       = 12;
   localparam int unsigned BLINK_FRAMES = 2;
   localparam logic [23:0] FG           = 24'hA0B0C0;
   localparam logic [23:0] BG           = 24'h102030;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [9:0]        h_pos = '0;
   logic [9:0]        v_pos = '0;
   logic              de_in = 1'b0;
   logic              hsync_in = 1'b0;
   logic              vsync_in = 1'b0;
   logic [ADDR_W-1:0] char_addr;
   logic [7:0]        char_data = '0;
   logic [7:0]        font_char;
   logic [3:0]        font_scanline;
   logic [7:0]        font_row = '0;
   logic [23:0]       fg_color = FG;
   logic [23:0]       bg_color = BG;
   logic              cursor_en = 1'b0;
   logic [6:0]        cursor_col = '0;
   logic [4:0]        cursor_row = '0;
   logic [23:0]       rgb_out;
   logic              de_out;
   logic              hsync_out;
   logic              vsync_out;

   logic [7:0]  ram_val = 8'h41;
   logic [7:0]  rom_val = 8'h18;
   logic [23:0] glyph_exp [8];
   logic [23:0] exp_rgb;
   logic        exp_de;
   logic [11:0] de_pat = 12'b0111_0011_0110;
   logic [11:0] hs_pat = 12'b0001_1110_0000;
   logic [11:0] vs_pat = 12'b1100_0000_0011;
   int          cur_pulses [7] = '{0, 1, 1, 0, 0, 1, 1};
   int          cur_v      [7] = '{46, 46, 46, 45, 46, 46, 46};
   int          cur_h      [7] = '{24, 24, 24, 24, 32, 24, 24};
   logic        cur_fg     [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

   int checks = 0;
   int errors = 0;

   char_glyph_renderer #(
      .COLS        (COLS),
      .ROWS        (ROWS),
      .ADDR_W      (ADDR_W),
      .BLINK_FRAMES(BLINK_FRAMES)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .h_pos        (h_pos),
      .v_pos        (v_pos),
      .de_in        (de_in),
      .hsync_in     (hsync_in),
      .vsync_in     (vsync_in),
      .char_addr    (char_addr),
      .char_data    (char_data),
      .font_char    (font_char),
      .font_scanline(font_scanline),
      .font_row     (font_row),
      .fg_color     (fg_color),
      .bg_color     (bg_color),
      .cursor_en    (cursor_en),
      .cursor_col   (cursor_col),
      .cursor_row   (cursor_row),
      .rgb_out      (rgb_out),
      .de_out       (de_out),
      .hsync_out    (hsync_out),
      .vsync_out    (vsync_out)
   );

   always #5 clk = ~clk;

   // Sync RAM and ROM: one-cycle read latency; ROM answers only for the character the RAM gave.
   always @(posedge clk) begin
      char_data <= ram_val;
      font_row  <= (font_char == ram_val) ? rom_val : ~rom_val;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      de_in = 1'b0;
      hsync_in = 1'b0;
      vsync_in = 1'b0;
      repeat (n) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      checks++;
      if (rgb_out !== 24'h0) begin
         errors++; $display("FAIL reset_rgb: got %h expected %h", rgb_out, 24'h0);
      end
      checks++;
      if (de_out !== 1'b0) begin
         errors++; $display("FAIL reset_de: got %b expected 0", de_out);
      end
      checks++;
      if (hsync_out !== 1'b0 || vsync_out !== 1'b0) begin
         errors++; $display("FAIL reset_sync: got %b%b expected 00", hsync_out, vsync_out);
      end
      checks++;
      if (char_addr !== '0) begin
         errors++; $display("FAIL reset_addr: got %0d expected 0", char_addr);
      end
      rst_n = 1'b1;
      idle(4);
   endtask

   task automatic test_glyph();
      glyph_exp = '{BG, BG, BG, FG, FG, BG, BG, BG};
      ram_val = 8'h41;
      rom_val = 8'h18;
      v_pos = 10'd0;
      for (int c = 0; c < 12; c++) begin
         if (c < 8) begin
            h_pos = 10'(c);
            de_in = 1'b1;
         end else begin
            de_in = 1'b0;
         end
         tick();
         if (c == 0) begin
            checks++;
            if (char_addr !== 12'd0) begin
               errors++; $display("FAIL glyph_addr: got %0d expected 0", char_addr);
            end
         end
         if (c == 1) begin
            checks++;
            if (font_char !== 8'h41) begin
               errors++; $display("FAIL glyph_font_char: got %h expected 41", font_char);
            end
         end
         if (c >= 3 && c < 11) begin
            exp_rgb = glyph_exp[c-3];
            exp_de  = 1'b1;
         end else begin
            exp_rgb = 24'h0;
            exp_de  = 1'b0;
         end
         checks++;
         if (rgb_out !== exp_rgb || de_out !== exp_de) begin
            errors++;
            $display("FAIL glyph_px c=%0d: got rgb=%h de=%b expected rgb=%h de=%b",
                     c, rgb_out, de_out, exp_rgb, exp_de);
         end
      end
      idle(4);
   endtask

   task automatic test_addr();
      h_pos = 10'd17;
      v_pos = 10'd37;
      de_in = 1'b1;
      tick();
      checks++;
      if (char_addr !== 12'd162) begin
         errors++; $display("FAIL addr_162: got %0d expected 162", char_addr);
      end
      de_in = 1'b0;
      tick();
      checks++;
      if (font_scanline !== 4'd5) begin
         errors++; $display("FAIL addr_scanline5: got %0d expected 5", font_scanline);
      end
      checks++;
      if (char_addr !== 12'd162) begin
         errors++; $display("FAIL addr_hold_de0: got %0d expected 162", char_addr);
      end
      h_pos = 10'd639;
      v_pos = 10'd479;
      de_in = 1'b1;
      tick();
      checks++;
      if (char_addr !== 12'd2399) begin
         errors++; $display("FAIL addr_last_cell: got %0d expected 2399", char_addr);
      end
      de_in = 1'b0;
      tick();
      checks++;
      if (font_scanline !== 4'd15) begin
         errors++; $display("FAIL addr_scanline15: got %0d expected 15", font_scanline);
      end
      idle(4);
   endtask

   task automatic test_sync();
      ram_val = 8'h41;
      rom_val = 8'h18;
      h_pos = 10'd0;
      v_pos = 10'd0;
      for (int c = 0; c < 16; c++) begin
         if (c < 12) begin
            de_in    = de_pat[c];
            hsync_in = hs_pat[c];
            vsync_in = vs_pat[c];
         end else begin
            de_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
         end
         tick();
         if (c >= 3 && c < 15) begin
            checks++;
            if (de_out !== de_pat[c-3] || hsync_out !== hs_pat[c-3] ||
                vsync_out !== vs_pat[c-3]) begin
               errors++;
               $display("FAIL sync_delay c=%0d: got de/hs/vs=%b%b%b expected %b%b%b", c,
                        de_out, hsync_out, vsync_out, de_pat[c-3], hs_pat[c-3], vs_pat[c-3]);
            end
            exp_rgb = de_pat[c-3] ? BG : 24'h0;
            checks++;
            if (rgb_out !== exp_rgb) begin
               errors++; $display("FAIL sync_rgb c=%0d: got %h expected %h", c, rgb_out, exp_rgb);
            end
         end else if (c < 3) begin
            checks++;
            if (de_out !== 1'b0 || hsync_out !== 1'b0 || vsync_out !== 1'b0) begin
               errors++;
               $display("FAIL sync_early c=%0d: got de/hs/vs=%b%b%b expected 000", c,
                        de_out, hsync_out, vsync_out);
            end
         end
      end
      idle(4);
   endtask

   task automatic test_out_of_range();
      rom_val = 8'hFF;
      for (int c = 0; c < 7; c++) begin
         de_in = 1'b1;
         case (c)
            0:       begin h_pos = 10'd17;  v_pos = 10'd37;  end
            1:       begin h_pos = 10'd640; v_pos = 10'd37;  end
            2:       begin h_pos = 10'd0;   v_pos = 10'd480; end
            default: de_in = 1'b0;
         endcase
         tick();
         if (c == 1 || c == 2) begin
            checks++;
            if (char_addr !== 12'd162) begin
               errors++; $display("FAIL oob_addr_hold c=%0d: got %0d expected 162", c, char_addr);
            end
         end
         if (c >= 3) begin
            exp_rgb = (c == 3) ? FG : (c == 6) ? 24'h0 : BG;
            exp_de  = (c != 6);
            checks++;
            if (rgb_out !== exp_rgb || de_out !== exp_de) begin
               errors++;
               $display("FAIL oob_rgb c=%0d: got rgb=%h de=%b expected rgb=%h de=%b",
                        c, rgb_out, de_out, exp_rgb, exp_de);
            end
         end
      end
      idle(4);
   endtask

   task automatic test_cursor();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      idle(2);
      cursor_en  = 1'b1;
      cursor_col = 7'd3;
      cursor_row = 5'd2;
      ram_val = 8'h41;
      rom_val = 8'h00;
      for (int k = 0; k < 7; k++) begin
         repeat (cur_pulses[k]) begin
            vsync_in = 1'b1;
            tick();
            vsync_in = 1'b0;
            tick();
         end
         v_pos = 10'(cur_v[k]);
         for (int c = 0; c < 11; c++) begin
            if (c < 8) begin
               h_pos = 10'(cur_h[k] + c);
               de_in = 1'b1;
            end else begin
               de_in = 1'b0;
            end
            tick();
            if (c >= 3) begin
               exp_rgb = cur_fg[k] ? FG : BG;
               checks++;
               if (rgb_out !== exp_rgb) begin
                  errors++;
                  $display("FAIL cursor k=%0d c=%0d: got %h expected %h", k, c, rgb_out, exp_rgb);
               end
            end
         end
      end
      cursor_en = 1'b0;
      idle(4);
   endtask

   task automatic test_reset_midline();
      glyph_exp = '{BG, BG, BG, FG, FG, BG, BG, BG};
      ram_val = 8'h41;
      rom_val = 8'h18;
      v_pos = 10'd0;
      for (int c = 0; c < 6; c++) begin
         h_pos = 10'(c);
         de_in = 1'b1;
         tick();
      end
      checks++;
      if (de_out !== 1'b1 || rgb_out !== BG) begin
         errors++;
         $display("FAIL midline_pre: got rgb=%h de=%b expected rgb=%h de=1", rgb_out, de_out, BG);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (rgb_out !== 24'h0 || de_out !== 1'b0) begin
         errors++;
         $display("FAIL midline_async: got rgb=%h de=%b expected rgb=0 de=0", rgb_out, de_out);
      end
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         h_pos = 10'(c);
         de_in = 1'b1;
         tick();
         exp_rgb = (c >= 3) ? glyph_exp[c-3] : 24'h0;
         exp_de  = (c >= 3);
         checks++;
         if (rgb_out !== exp_rgb || de_out !== exp_de) begin
            errors++;
            $display("FAIL midline_after c=%0d: got rgb=%h de=%b expected rgb=%h de=%b",
                     c, rgb_out, de_out, exp_rgb, exp_de);
         end
      end
      idle(4);
   endtask

   initial begin
      test_reset();
      test_glyph();
      test_addr();
      test_sync();
      test_out_of_range();
      test_cursor();
      test_reset_midline();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
